instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/fetch_pkg.sv | 19 +
 rtl/instr_fetch_unit_if.sv | 28 ++
 rtl/fetch_timer.sv | 29 ++
 rtl/instr_fetch_unit.sv | 130 +++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      FAULT = 2'd2
   } fetch_state_e;

   // addi x0,x0,0 -- a harmless NOP loaded after reset and after any fault
   localparam word_t RESET_INSTR_DEFAULT = 32'h0000_0013;

   function automatic logic is_word_aligned(input word_t addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Control-side request/response and instruction-memory signals of the fetch unit.
// master is the fetch unit itself; slave is the surrounding control and memory.
interface instr_fetch_unit_if;
   import fetch_pkg::*;

   logic  Load_ir;
   word_t pc;
   logic  flush;
   logic  imem_req;
   word_t imem_addr;
   word_t imem_rdata;
   logic  imem_ack;
   word_t Instruction;
   logic  instr_valid;
   logic  fetch_busy;
   logic  fetch_fault;

   modport master (
      input  Load_ir, pc, flush, imem_rdata, imem_ack,
      output imem_req, imem_addr, Instruction, instr_valid, fetch_busy, fetch_fault
   );

   modport slave (
      output Load_ir, pc, flush, imem_rdata, imem_ack,
      input  imem_req, imem_addr, Instruction, instr_valid, fetch_busy, fetch_fault
   );

endinterface

// File: rtl/fetch_timer.sv
// Counts BUSY cycles of a fetch; expired is high on the last allowed cycle.
// Synchronous clear wins over enable; the count wraps only if left enabled past LIMIT.
module fetch_timer #(
   parameter int unsigned LIMIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [7:0] LAST = 8'(LIMIT - 1);

   logic [7:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 8'd1;
      end
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches one word per Load_ir into the instruction register; done two edges after the request at best.
// Holds imem_req until ack, timeout or flush; misaligned pc or timeout gives a one-cycle FAULT.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter word_t       RESET_INSTR    = RESET_INSTR_DEFAULT
) (
   input logic                clk,
   input logic                reset,
   instr_fetch_unit_if.master bus
);

   fetch_state_e state_q, state_d;

   logic  req_q,   req_d;
   word_t addr_q,  addr_d;
   word_t instr_q, instr_d;
   logic  valid_q, valid_d;
   logic  busy_q,  busy_d;

   logic timer_clear;
   logic timer_enable;
   logic timer_expired;

   fetch_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (timer_clear),
      .enable  (timer_enable),
      .expired (timer_expired)
   );

   assign timer_enable = (state_q == BUSY);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         addr_q  <= '0;
         instr_q <= RESET_INSTR;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      addr_d      = addr_q;
      instr_d     = instr_q;
      valid_d     = valid_q;
      busy_d      = busy_q;
      timer_clear = 1'b0;

      // flush outranks every other input, including an ack in the same cycle
      if (bus.flush) begin
         state_d = IDLE;
         req_d   = 1'b0;
         busy_d  = 1'b0;
         valid_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.Load_ir) begin
                  if (is_word_aligned(bus.pc)) begin
                     state_d     = BUSY;
                     addr_d      = bus.pc;
                     valid_d     = 1'b0;
                     req_d       = 1'b1;
                     busy_d      = 1'b1;
                     timer_clear = 1'b1;
                  end else begin
                     state_d = FAULT;
                     instr_d = RESET_INSTR;
                     valid_d = 1'b1;
                     req_d   = 1'b0;
                     busy_d  = 1'b1;
                  end
               end
            end

            BUSY: begin
               // an ack on the final allowed cycle still completes the fetch
               if (bus.imem_ack) begin
                  state_d = IDLE;
                  instr_d = bus.imem_rdata;
                  valid_d = 1'b1;
                  req_d   = 1'b0;
                  busy_d  = 1'b0;
               end else if (timer_expired) begin
                  state_d = FAULT;
                  instr_d = RESET_INSTR;
                  valid_d = 1'b1;
                  req_d   = 1'b0;
                  busy_d  = 1'b1;
               end
            end

            FAULT: begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end

            default: begin
               state_d = IDLE;
               req_d   = 1'b0;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   assign bus.imem_req    = req_q;
   assign bus.imem_addr   = addr_q;
   assign bus.Instruction = instr_q;
   assign bus.instr_valid = valid_q;
   assign bus.fetch_busy  = busy_q;
   assign bus.fetch_fault = (state_q == FAULT);

endmodule
